// File: rtl/ex_stage_ctrl.sv
// ----------------------------------------------------------------------------
// ex_stage_ctrl
//   Execute-stage pipeline controller. Instructions arrive from ID over a
//   valid/ready handshake, sit in the EX operand register (which feeds a
//   purely combinational ALU outside this block) and the ALU result is
//   captured in the EX/MEM register. A one-entry skid buffer lets the ID-side
//   ready be a flop, so no combinational path exists from i_mem_ready to
//   o_id_ready. A redirect (i_flush) kills EX and skid contents but leaves the
//   older MEM entry alone. A saturating counter tracks cycles EX was blocked.
//
// Ports
//   clk, rst_n      clock (rising edge) / asynchronous active-low reset
//   i_id_struct     instruction bundle from ID
//   i_id_valid      i_id_struct valid
//   o_id_ready      registered ready toward ID
//   o_alu_struct    EX operand register to the ALU (is_valid = EX occupied)
//   i_alu_struct    ALU result bundle, combinational from o_alu_struct
//   o_mem_struct    registered EX/MEM bundle
//   o_mem_valid     o_mem_struct valid
//   i_mem_ready     MEM consumes o_mem_struct this cycle
//   i_flush         redirect: kill EX and skid contents
//   o_stall_cnt     saturating count of EX stall cycles
//   o_busy          any valid entry held (EX, skid or MEM)
// ----------------------------------------------------------------------------
package ex_stage_pkg;
  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rf_wr_data;
  } interconnection_struct;
endpackage

module ex_stage_ctrl
  import ex_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  interconnection_struct i_id_struct,
  input  logic                  i_id_valid,
  output logic                  o_id_ready,
  output interconnection_struct o_alu_struct,
  input  interconnection_struct i_alu_struct,
  output interconnection_struct o_mem_struct,
  output logic                  o_mem_valid,
  input  logic                  i_mem_ready,
  input  logic                  i_flush,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic                  o_busy
);

  // Occupancy is encoded directly as {ex_valid, skid_valid}; 2'b01 (skid
  // holding while EX is empty) has no name and must never be reached.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b10,
    OCC_FULL  = 2'b11
  } occ_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_t                  r_occ;
  occ_t                  w_occ_next;
  interconnection_struct r_ex;
  interconnection_struct r_skid;
  interconnection_struct r_mem;
  logic                  r_mem_valid;
  logic                  r_id_ready;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic w_ex_valid;
  logic w_skid_valid;
  logic w_accept;
  logic w_ex_adv;
  logic w_ex_free;
  logic w_ex_valid_next;
  logic w_skid_valid_next;
  logic w_ex_load_skid;
  logic w_ex_load_in;
  logic w_skid_load;

  assign w_ex_valid   = r_occ[1];
  assign w_skid_valid = r_occ[0];

  assign w_accept  = i_id_valid & r_id_ready;
  assign w_ex_adv  = w_ex_valid & (~r_mem_valid | i_mem_ready);
  assign w_ex_free = ~w_ex_valid | w_ex_adv;

  // --------------------------------------------------------------------------
  // Occupancy FSM: next state and load strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_ex_valid_next   = w_ex_valid;
    w_skid_valid_next = w_skid_valid;
    w_ex_load_skid    = 1'b0;
    w_ex_load_in      = 1'b0;
    w_skid_load       = 1'b0;

    if (i_flush) begin
      // Anything accepted this cycle is dropped along with EX and skid.
      w_ex_valid_next   = 1'b0;
      w_skid_valid_next = 1'b0;
    end else begin
      // The skid entry is older than anything on the input, so it refills EX
      // first. While skid is valid o_id_ready is low, so accept cannot also
      // be high here.
      if (w_skid_valid && w_ex_free) begin
        w_ex_load_skid    = 1'b1;
        w_ex_valid_next   = 1'b1;
        w_skid_valid_next = 1'b0;
      end else if (w_accept && w_ex_free) begin
        w_ex_load_in    = 1'b1;
        w_ex_valid_next = 1'b1;
      end else if (w_ex_adv) begin
        w_ex_valid_next = 1'b0;
      end

      // EX is blocked: park the accepted instruction in the skid buffer.
      if (w_accept && !w_ex_free) begin
        w_skid_load       = 1'b1;
        w_skid_valid_next = 1'b1;
      end
    end

    w_occ_next = occ_t'({w_ex_valid_next, w_skid_valid_next});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= OCC_EMPTY;
      r_id_ready <= 1'b1;
    end else begin
      r_occ      <= w_occ_next;
      // Ready only drops when the skid will be holding an entry.
      r_id_ready <= ~w_skid_valid_next;
    end
  end

  // --------------------------------------------------------------------------
  // EX operand register and skid buffer payloads
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex   <= '0;
      r_skid <= '0;
    end else begin
      if (w_ex_load_skid) begin
        r_ex <= r_skid;
      end else if (w_ex_load_in) begin
        r_ex <= i_id_struct;
      end
      if (w_skid_load) begin
        r_skid <= i_id_struct;
      end
    end
  end

  // --------------------------------------------------------------------------
  // EX/MEM register. A flush never writes MEM, even if EX was advancing;
  // the entry already in MEM is older than the redirect and is kept.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem       <= '0;
      r_mem_valid <= 1'b0;
    end else if (w_ex_adv && !i_flush) begin
      r_mem       <= i_alu_struct;
      r_mem_valid <= 1'b1;
    end else if (i_mem_ready) begin
      r_mem_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating stall counter: EX holds an instruction that cannot move on.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_ex_valid && !w_ex_adv && !i_flush && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    o_alu_struct          = r_ex;
    o_alu_struct.is_valid = w_ex_valid;
  end

  assign o_id_ready   = r_id_ready;
  assign o_mem_struct = r_mem;
  assign o_mem_valid  = r_mem_valid;
  assign o_stall_cnt  = r_stall_cnt;
  assign o_busy       = w_ex_valid | w_skid_valid | r_mem_valid;

  a_occ_legal: assert property (@(posedge clk) disable iff (!rst_n)
    r_occ inside {OCC_EMPTY, OCC_ONE, OCC_FULL});

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_ctrl
//   Self-checking bench for ex_stage_ctrl. Two instances share the stimulus:
//   one with the default counter width and one with CNT_W=4 to exercise
//   counter saturation. A queue-based reference model predicts every output
//   each cycle; a table of directed vectors with hand-computed expectations
//   covers streaming and backpressure, and short sequences cover flush,
//   saturation and asynchronous reset. Random traffic finishes the run.
// ----------------------------------------------------------------------------
module tb_ex_stage_ctrl;
  import ex_stage_pkg::*;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  i_id_valid;
  logic                  i_mem_ready;
  logic                  i_flush;
  interconnection_struct i_id_struct;

  interconnection_struct alu_out, alu_res, mem_s;
  logic                  id_ready, mem_valid, busy;
  logic [31:0]           stall_cnt;

  interconnection_struct s_alu_out, s_alu_res, s_mem;
  logic                  s_ready, s_mvld, s_busy;
  logic [3:0]            s_stall;

  // Combinational ALU sitting between the operand and result ports.
  function automatic interconnection_struct alu_fn(input interconnection_struct s);
    interconnection_struct r;
    r = s;
    case (s.alu_op)
      OP_ADD:  r.rf_wr_data = s.rs1_data + s.rs2_data;
      OP_SUB:  r.rf_wr_data = s.rs1_data - s.rs2_data;
      OP_AND:  r.rf_wr_data = s.rs1_data & s.rs2_data;
      OP_OR:   r.rf_wr_data = s.rs1_data | s.rs2_data;
      OP_XOR:  r.rf_wr_data = s.rs1_data ^ s.rs2_data;
      default: r.rf_wr_data = s.rs1_data;
    endcase
    return r;
  endfunction

  assign alu_res   = alu_fn(alu_out);
  assign s_alu_res = alu_fn(s_alu_out);

  ex_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_struct(i_id_struct), .i_id_valid(i_id_valid), .o_id_ready(id_ready),
    .o_alu_struct(alu_out), .i_alu_struct(alu_res),
    .o_mem_struct(mem_s), .o_mem_valid(mem_valid), .i_mem_ready(i_mem_ready),
    .i_flush(i_flush), .o_stall_cnt(stall_cnt), .o_busy(busy)
  );

  ex_stage_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_id_struct(i_id_struct), .i_id_valid(i_id_valid), .o_id_ready(s_ready),
    .o_alu_struct(s_alu_out), .i_alu_struct(s_alu_res),
    .o_mem_struct(s_mem), .o_mem_valid(s_mvld), .i_mem_ready(i_mem_ready),
    .i_flush(i_flush), .o_stall_cnt(s_stall), .o_busy(s_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input interconnection_struct act,
                       input interconnection_struct exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic interconnection_struct mki(input logic [31:0] pc, input logic [3:0] op,
                                                input logic [31:0] a, input logic [31:0] b);
    interconnection_struct s;
    s          = '0;
    s.is_valid = 1'b1;
    s.pc       = pc;
    s.alu_op   = op;
    s.rd       = pc[6:2];
    s.rs1_data = a;
    s.rs2_data = b;
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: an ordered queue of instructions held in EX+skid
  // (head = EX), a MEM slot, and an unbounded stall tally.
  // --------------------------------------------------------------------------
  interconnection_struct m_q[$];
  interconnection_struct m_mem;
  logic                  m_mvld;
  logic                  m_rdy;
  longint unsigned       m_stall;

  task automatic model_reset();
    m_q.delete();
    m_mem   = '0;
    m_mvld  = 1'b0;
    m_rdy   = 1'b1;
    m_stall = 0;
  endtask

  task automatic model_step();
    logic                  acc;
    logic                  adv;
    interconnection_struct e;
    acc = i_id_valid && m_rdy;
    adv = (m_q.size() > 0) && (!m_mvld || i_mem_ready);
    if ((m_q.size() > 0) && !adv && !i_flush) m_stall++;
    if (i_flush) begin
      m_q.delete();
      if (i_mem_ready) m_mvld = 1'b0;
    end else begin
      if (adv) begin
        e          = m_q.pop_front();
        e.is_valid = 1'b1;
        m_mem      = alu_fn(e);
        m_mvld     = 1'b1;
      end else if (i_mem_ready) begin
        m_mvld = 1'b0;
      end
      if (acc) m_q.push_back(i_id_struct);
    end
    m_rdy = (m_q.size() < 2);
  endtask

  task automatic check_model();
    interconnection_struct e;
    logic                  hold;
    hold = (m_q.size() > 0);
    chk("id_ready", id_ready, m_rdy);
    chk("busy", busy, hold || m_mvld);
    chk("alu_valid", alu_out.is_valid, hold);
    if (hold) begin
      e          = m_q[0];
      e.is_valid = 1'b1;
      chk_s("alu_struct", alu_out, e);
    end
    chk("mem_valid", mem_valid, m_mvld);
    if (m_mvld) chk_s("mem_struct", mem_s, m_mem);
    chk("stall_cnt", stall_cnt, (m_stall > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall);
    chk("sat_stall_cnt", s_stall, (m_stall > 15) ? 64'd15 : m_stall);
    chk("sat_id_ready", s_ready, m_rdy);
    chk("sat_mem_valid", s_mvld, m_mvld);
    chk("sat_busy", s_busy, hold || m_mvld);
    if (m_mvld) chk_s("sat_mem_struct", s_mem, m_mem);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are compared
  // on the falling edge, then the model advances across the next edge.
  task automatic begin_cycle(input logic vld, input interconnection_struct din,
                             input logic mrdy, input logic fl);
    i_id_valid  = vld;
    i_id_struct = din;
    i_mem_ready = mrdy;
    i_flush     = fl;
    @(negedge clk);
    check_model();
  endtask

  task automatic end_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic mrdy);
    begin_cycle(1'b0, '0, mrdy, 1'b0);
    end_cycle();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic                  vld;
    interconnection_struct din;
    logic                  mrdy;
    logic                  e_rdy;
    logic                  e_mvld;
    logic [31:0]           e_pc;
    logic [31:0]           e_wd;
    logic [31:0]           e_stall;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mkv(input logic vld, input interconnection_struct din, input logic mrdy,
                               input logic e_rdy, input logic e_mvld, input logic [31:0] e_pc,
                               input logic [31:0] e_wd, input logic [31:0] e_stall);
    vec_t v;
    v.vld = vld; v.din = din; v.mrdy = mrdy;
    v.e_rdy = e_rdy; v.e_mvld = e_mvld; v.e_pc = e_pc; v.e_wd = e_wd; v.e_stall = e_stall;
    return v;
  endfunction

  initial begin
    interconnection_struct b0, b1, b2, b3;

    // Streaming: 8 back-to-back ADD 5+7, MEM always ready.
    for (int k = 0; k < 11; k++) begin
      tbl[k] = mkv(k < 8, mki(32'(4 * k), OP_ADD, 5, 7), 1'b1,
                   1'b1, (k >= 2) && (k <= 9), 32'(4 * (k - 2)), 32'd12, 32'd0);
    end
    // Backpressure: MEM stalled for 5 cycles, then ready.
    b0 = mki(32'h0, OP_ADD, 5, 7);
    b1 = mki(32'h4, OP_SUB, 20, 3);
    b2 = mki(32'h8, OP_XOR, 32'hF0, 32'h0F);
    b3 = mki(32'hC, OP_AND, 32'hFF, 32'h3C);
    tbl[11] = mkv(1, b0, 0, 1, 0, 32'h0, 32'd0,  32'd0);
    tbl[12] = mkv(1, b1, 0, 1, 0, 32'h0, 32'd0,  32'd0);
    tbl[13] = mkv(1, b2, 0, 1, 1, 32'h0, 32'd12, 32'd0);
    tbl[14] = mkv(1, b3, 0, 0, 1, 32'h0, 32'd12, 32'd1);
    tbl[15] = mkv(1, b3, 0, 0, 1, 32'h0, 32'd12, 32'd2);
    tbl[16] = mkv(1, b3, 1, 0, 1, 32'h0, 32'd12, 32'd3);
    tbl[17] = mkv(1, b3, 1, 1, 1, 32'h4, 32'd17, 32'd3);
    tbl[18] = mkv(0, b3, 1, 1, 1, 32'h8, 32'hFF, 32'd3);
    tbl[19] = mkv(0, b3, 1, 1, 1, 32'hC, 32'h3C, 32'd3);
    tbl[20] = mkv(0, b3, 1, 1, 0, 32'h0, 32'd0,  32'd3);

    i_id_valid  = 1'b0;
    i_id_struct = '0;
    i_mem_ready = 1'b0;
    i_flush     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("por_ready", id_ready, 1);
    chk("por_mem_valid", mem_valid, 0);
    chk("por_stall", stall_cnt, 0);
    chk("por_busy", busy, 0);
    chk_s("por_mem_struct", mem_s, '0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      begin_cycle(tbl[i].vld, tbl[i].din, tbl[i].mrdy, 1'b0);
      chk($sformatf("tbl%0d_ready", i), id_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_mem_valid", i), mem_valid, tbl[i].e_mvld);
      if (tbl[i].e_mvld) begin
        chk($sformatf("tbl%0d_mem_pc", i), mem_s.pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_mem_wdata", i), mem_s.rf_wr_data, tbl[i].e_wd);
      end
      chk($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].e_stall);
      end_cycle();
    end

    // Flush with the pipe full: 0x10 in MEM, 0x14 in EX, 0x18 in skid.
    begin_cycle(1, mki(32'h10, OP_ADD, 1, 2), 0, 0);      end_cycle();
    begin_cycle(1, mki(32'h14, OP_SUB, 9, 4), 0, 0);      end_cycle();
    begin_cycle(1, mki(32'h18, OP_OR, 32'hA0, 5), 0, 0);  end_cycle();
    begin_cycle(1, mki(32'h1C, OP_ADD, 3, 3), 0, 1);
    chk("flush_full_ready", id_ready, 0);
    chk("flush_ex_pc", alu_out.pc, 32'h14);
    chk("flush_mem_pc_before", mem_s.pc, 32'h10);
    end_cycle();
    // Ready is back; an input accepted under flush must vanish.
    begin_cycle(1, mki(32'h20, OP_ADD, 1, 1), 0, 1);
    chk("flush_ready_after", id_ready, 1);
    chk("flush_mem_kept_valid", mem_valid, 1);
    chk("flush_mem_kept_pc", mem_s.pc, 32'h10);
    chk("flush_ex_killed", alu_out.is_valid, 0);
    end_cycle();
    begin_cycle(0, '0, 1, 0);
    chk("flush_discard_in", alu_out.is_valid, 0);
    chk("flush_mem_pc_consume", mem_s.pc, 32'h10);
    end_cycle();
    repeat (4) begin
      begin_cycle(0, '0, 1, 0);
      chk("flush_no_emit", mem_valid, 0);
      end_cycle();
    end

    // Saturation: fill the pipe and hold MEM stalled for 20 cycles.
    begin_cycle(1, mki(32'h40, OP_ADD, 1, 1), 0, 0); end_cycle();
    begin_cycle(1, mki(32'h44, OP_ADD, 2, 2), 0, 0); end_cycle();
    begin_cycle(1, mki(32'h48, OP_ADD, 3, 3), 0, 0); end_cycle();
    repeat (20) idle_cycle(1'b0);
    begin_cycle(0, '0, 0, 0);
    chk("sat_at_max", s_stall, 15);
    chk("sat_pipe_full_ready", id_ready, 0);
    end_cycle();
    begin_cycle(0, '0, 0, 0);
    chk("sat_holds_max", s_stall, 15);
    end_cycle();

    // Asynchronous reset in mid-cycle with the pipe still full.
    i_id_valid  = 1'b1;
    i_id_struct = mki(32'h50, OP_ADD, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_ready", id_ready, 1);
    chk("areset_mem_valid", mem_valid, 0);
    chk("areset_stall", stall_cnt, 0);
    chk("areset_sat_stall", s_stall, 0);
    chk("areset_busy", busy, 0);
    chk("areset_alu_valid", alu_out.is_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      begin_cycle($urandom_range(0, 9) < 7,
                  mki($urandom, 4'($urandom_range(0, 5)), $urandom, $urandom),
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
      end_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage_ctrl.md
Name: ex_stage_ctrl

Overview:
Pipeline controller for the execute stage.
- Accepts decoded instructions from ID through a valid/ready handshake.
- Holds each instruction in an EX operand register that drives the combinational ALU.
- Registers the ALU result into the EX/MEM output register.
- Provides a 1-entry skid buffer so the ID-side ready is registered, plus younger-instruction flush on redirect and a saturating stall-cycle counter.

Parameters:
CNT_W, 32, width of the stall-cycle counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_id_struct  in  interconnection_struct  instruction bundle from ID
i_id_valid  in  1  i_id_struct valid
o_id_ready  out  1  registered; controller can accept this cycle
o_alu_struct  out  interconnection_struct  EX operand register to ALU; is_valid forced to ex_valid
i_alu_struct  in  interconnection_struct  ALU result bundle (combinational from o_alu_struct)
o_mem_struct  out  interconnection_struct  registered EX/MEM bundle
o_mem_valid  out  1  o_mem_struct valid
i_mem_ready  in  1  MEM stage consumes o_mem_struct this cycle
i_flush  in  1  redirect; kill EX and skid contents
o_stall_cnt  out  CNT_W  saturating count of EX stall cycles
o_busy  out  1  any valid entry held (ex, skid or mem)

Behaviour:
- Reset: async on rst_n low, all registers cleared.
  - ex_valid=0, skid_valid=0, o_mem_valid=0, o_id_ready=1, o_stall_cnt=0.
  - o_alu_struct, o_mem_struct and skid contents all zero.
- Definitions:
  - accept = i_id_valid & o_id_ready.
  - ex_adv = ex_valid & (~o_mem_valid | i_mem_ready).
  - ex_free = ~ex_valid | ex_adv.
- Occupancy states, encoded by (ex_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is illegal and must never occur; assert it.
- EX register update, in priority order:
  - i_flush: ex_valid<=0.
  - Else if skid_valid & ex_free: ex<=skid, skid_valid<=0.
  - Else if accept & ex_free: ex<=i_id_struct, ex_valid<=1.
  - Else if ex_adv: ex_valid<=0.
  - Else hold.
- Skid update:
  - i_flush: skid_valid<=0.
  - Else if accept & ~ex_free: skid<=i_id_struct, skid_valid<=1.
  - Skid and EX are never loaded from the input in the same cycle.
- o_id_ready next value = ~next_skid_valid, i.e. deasserts only when the skid buffer will hold an entry. Combinational ready from i_mem_ready is forbidden.
- MEM register update:
  - If ex_adv & ~i_flush: o_mem_struct<=i_alu_struct, o_mem_valid<=1.
  - Else if i_mem_ready: o_mem_valid<=0.
  - Simultaneous consume and refill keeps o_mem_valid=1 with the new data.
- Flush:
  - Applies to EX and skid only; o_mem_struct is older and is retained.
  - An input accepted in the flush cycle is discarded.
  - Flush takes effect at the clock edge: ex_adv in the flush cycle does not write MEM.
- Latency: accept at edge N -> EX at N+1 -> o_mem_valid at N+2 with no backpressure. Throughput is 1 per cycle.
- Backpressure: with i_mem_ready held low and the pipe full, o_id_ready falls one cycle after the first unconsumed accept into the skid. No instruction is dropped or duplicated, and order is preserved.
- Stall counter:
  - Increments by 1 on each cycle with ex_valid & ~ex_adv & ~i_flush.
  - Saturates at 2^CNT_W-1; never wraps.
  - Cleared only by reset.
- o_busy = ex_valid | skid_valid | o_mem_valid (combinational).
- The ALU is combinational, so i_alu_struct is sampled in the same cycle that o_alu_struct is presented. The controller does not alter ALU result fields.

Test Plan:
- Reset: drive rst_n low mid-stream with the pipe FULL -> outputs return immediately (asynchronously) to o_id_ready=1, o_mem_valid=0, o_stall_cnt=0, o_busy=0.
- Streaming: 8 back-to-back ADD rs1=5, rs2=7, i_mem_ready=1 -> first o_mem_valid 2 cycles after first accept; 8 consecutive results with rf_wr_data=12; o_stall_cnt=0.
- Backpressure: 4 instrs tagged by pc 0x0,0x4,0x8,0xC, i_mem_ready=0 for 5 cycles then 1:
  - o_id_ready drops after the skid fills.
  - Outputs appear in order 0x0,0x4,0x8,0xC with none lost or duplicated.
  - o_stall_cnt counts exactly the EX-blocked cycles.
- Flush: pipe FULL (pc 0x10 in MEM, 0x14 in EX, 0x18 in skid), assert i_flush with a new input valid:
  - 0x10 remains on o_mem_struct.
  - 0x14, 0x18 and the new input are never emitted.
  - o_id_ready=1 the next cycle.
- Simultaneous consume/refill: o_mem_valid=1, i_mem_ready=1 and ex_valid=1 in the same cycle -> o_mem_valid stays 1 and o_mem_struct is updated to the EX instruction's result.
- Saturation: CNT_W=4, hold i_mem_ready=0 for 20 cycles with EX occupied -> o_stall_cnt reaches 15 and stays at 15.
